// File: rtl/bg_scan_addr_gen.sv
// Raster scan generator for background ROM readers: 640x480 timing, 4x-scaled
// texel addressing with a per-frame wrapping horizontal scroll, sync delayed to match RGB.
module bg_scan_addr_gen #(
    parameter int H_VISIBLE   = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_VISIBLE   = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int IMG_W       = 160,
    parameter int IMG_H       = 120,
    parameter int SCALE_SHIFT = 2,
    parameter int ADDR_W      = 15
) (
    input  logic              vga_clk,
    input  logic              reset,
    input  logic [7:0]        scroll_x,
    input  logic              scroll_en,
    output logic [ADDR_W-1:0] rom_address,
    output logic              blank,
    output logic [9:0]        draw_x,
    output logic [9:0]        draw_y,
    output logic              hs,
    output logic              vs,
    output logic              frame_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FP + V_SYNC);

    localparam logic [SCALE_SHIFT-1:0] SUB_LAST = '1;
    localparam logic [SCALE_SHIFT-1:0] SUB_ONE  = SCALE_SHIFT'(1);
    localparam logic [7:0]             U_LAST   = 8'(IMG_W - 1);
    localparam logic [7:0]             IMG_W8   = 8'(IMG_W);
    localparam logic [ADDR_W-1:0]      ROW_STEP = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0]      LAST_ROW = ADDR_W'((IMG_H - 1) * IMG_W);

    logic [9:0]             h_cnt, v_cnt, h_nxt, v_nxt;
    logic                   line_wrap, vis_nxt, hs_raw, vs_raw, hs_raw_nxt, vs_raw_nxt;
    logic [7:0]             scroll_q, scroll_wrapped, u, u_nxt;
    logic                   scroll_load;
    logic [SCALE_SHIFT-1:0] sub, sub_nxt, vsub, vsub_nxt;
    logic [ADDR_W-1:0]      row_base, row_nxt, addr_nxt;

    // Everything is computed for the pixel about to be presented, then registered.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        row_nxt  = row_base;
        vsub_nxt = vsub;
        u_nxt    = u;
        sub_nxt  = sub + SUB_ONE;

        line_wrap = (h_cnt == H_LAST);
        h_nxt     = line_wrap ? 10'd0 : h_cnt + 10'd1;
        v_nxt     = v_cnt;
        if (line_wrap)
            v_nxt = (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;

        vis_nxt    = (h_nxt < H_VIS) && (v_nxt < V_VIS);
        hs_raw_nxt = !((h_nxt >= HS_START) && (h_nxt < HS_END));
        vs_raw_nxt = !((v_nxt >= VS_START) && (v_nxt < VS_END));

        if (h_nxt == 10'd0) begin
            u_nxt   = scroll_q;
            sub_nxt = '0;
        end else if (sub == SUB_LAST) begin
            u_nxt = (u == U_LAST) ? 8'd0 : u + 8'd1;
        end

        // Row base holds at the last image row, keeping it inside the ROM during vblank.
        if (line_wrap) begin
            if (v_nxt == 10'd0) begin
                row_nxt  = '0;
                vsub_nxt = '0;
            end else begin
                vsub_nxt = vsub + SUB_ONE;
                if (vsub == SUB_LAST && row_base != LAST_ROW)
                    row_nxt = row_base + ROW_STEP;
            end
        end

        addr_nxt = vis_nxt ? row_nxt + ADDR_W'(u_nxt) : '0;

        // scroll_x < 2*IMG_W, so a single conditional subtraction wraps it.
        scroll_wrapped = (scroll_x >= IMG_W8) ? scroll_x - IMG_W8 : scroll_x;
        scroll_load    = line_wrap && (v_nxt == V_VIS) && scroll_en;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            h_cnt       <= H_LAST;
            v_cnt       <= V_LAST;
            draw_x      <= '0;
            draw_y      <= '0;
            blank       <= 1'b0;
            rom_address <= '0;
            frame_start <= 1'b0;
            hs_raw      <= 1'b1;
            vs_raw      <= 1'b1;
            hs          <= 1'b1;
            vs          <= 1'b1;
            scroll_q    <= '0;
            u           <= '0;
            sub         <= '0;
            vsub        <= '0;
            row_base    <= '0;
        end else begin
            h_cnt       <= h_nxt;
            v_cnt       <= v_nxt;
            draw_x      <= h_nxt;
            draw_y      <= v_nxt;
            blank       <= vis_nxt;
            rom_address <= addr_nxt;
            frame_start <= (h_nxt == 10'd0) && (v_nxt == 10'd0);
            hs_raw      <= hs_raw_nxt;
            vs_raw      <= vs_raw_nxt;
            hs          <= hs_raw;
            vs          <= vs_raw;
            u           <= u_nxt;
            sub         <= sub_nxt;
            vsub        <= vsub_nxt;
            row_base    <= row_nxt;
            if (scroll_load)
                scroll_q <= scroll_wrapped;
        end
    end

endmodule

// File: tb/tb_bg_scan_addr_gen.sv
// Bench for bg_scan_addr_gen: a full-size instance and a short-frame instance, both
// compared every cycle against a pixel-arithmetic reference model.
module tb_bg_scan_addr_gen;

    localparam int ADDR_W = 15;
    localparam int N      = 2;

    logic              vga_clk = 1'b0;
    logic              reset;
    logic [7:0]        scroll_x;
    logic              scroll_en;
    logic [ADDR_W-1:0] rom_address [N];
    logic              blank       [N];
    logic [9:0]        draw_x      [N];
    logic [9:0]        draw_y      [N];
    logic              hs          [N];
    logic              vs          [N];
    logic              frame_start [N];

    always #5 vga_clk = ~vga_clk;

    bg_scan_addr_gen u_full (
        .vga_clk(vga_clk), .reset(reset), .scroll_x(scroll_x), .scroll_en(scroll_en),
        .rom_address(rom_address[0]), .blank(blank[0]), .draw_x(draw_x[0]), .draw_y(draw_y[0]),
        .hs(hs[0]), .vs(vs[0]), .frame_start(frame_start[0])
    );

    // Only 12 lines per frame so several frames (scroll latching, frame period) fit the run.
    bg_scan_addr_gen #(.V_VISIBLE(8), .V_FP(1), .V_SYNC(2), .V_BP(1), .IMG_H(2)) u_small (
        .vga_clk(vga_clk), .reset(reset), .scroll_x(scroll_x), .scroll_en(scroll_en),
        .rom_address(rom_address[1]), .blank(blank[1]), .draw_x(draw_x[1]), .draw_y(draw_y[1]),
        .hs(hs[1]), .vs(vs[1]), .frame_start(frame_start[1])
    );

    // Reference timing for each instance
    localparam int H_TOT  = 800;
    localparam int HS_LO  = 656;
    localparam int HS_HI  = 752;
    int v_vis [N] = '{480, 8};
    int vs_lo [N] = '{490, 9};
    int vs_hi [N] = '{492, 11};
    int v_tot [N] = '{525, 12};

    int tests = 0;
    int fails = 0;

    // Model state: position presented, frame scroll, and previous pixel's raw sync
    bit started;
    int mx [N], my [N], scroll [N];
    bit prev_hs [N], prev_vs [N];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        started = 1'b0;
        for (int i = 0; i < N; i++) begin
            mx[i] = 0; my[i] = 0; scroll[i] = 0;
            prev_hs[i] = 1'b1; prev_vs[i] = 1'b1;
        end
    endtask

    task automatic tick();
        @(posedge vga_clk);
        if (reset) begin
            model_reset();
        end else if (!started) begin
            started = 1'b1;
        end else begin
            for (int i = 0; i < N; i++) begin
                prev_hs[i] = !(mx[i] >= HS_LO && mx[i] < HS_HI);
                prev_vs[i] = !(my[i] >= vs_lo[i] && my[i] < vs_hi[i]);
                mx[i]++;
                if (mx[i] == H_TOT) begin
                    mx[i] = 0;
                    my[i] = (my[i] + 1) % v_tot[i];
                end
                if (mx[i] == 0 && my[i] == v_vis[i] && scroll_en)
                    scroll[i] = (scroll_x < 160) ? int'(scroll_x) : int'(scroll_x) - 160;
            end
        end
        @(negedge vga_clk);
    endtask

    task automatic check_all();
        for (int i = 0; i < N; i++) begin
            bit vis;
            int addr;
            string p;
            vis  = started && mx[i] < 640 && my[i] < v_vis[i];
            addr = vis ? (my[i] / 4) * 160 + ((mx[i] / 4 + scroll[i]) % 160) : 0;
            p    = $sformatf("dut%0d(%0d,%0d)", i, mx[i], my[i]);
            check({p, " draw_x"},      32'(draw_x[i]),      32'(mx[i]));
            check({p, " draw_y"},      32'(draw_y[i]),      32'(my[i]));
            check({p, " blank"},       32'(blank[i]),       32'(vis));
            check({p, " rom_address"}, 32'(rom_address[i]), 32'(addr));
            check({p, " frame_start"}, 32'(frame_start[i]), 32'(started && mx[i] == 0 && my[i] == 0));
            check({p, " hs"},          32'(hs[i]),          32'(prev_hs[i]));
            check({p, " vs"},          32'(vs[i]),          32'(prev_vs[i]));
        end
    endtask

    task automatic run(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            tick();
            check_all();
        end
    endtask

    initial begin
        reset     = 1'b1;
        scroll_x  = 8'd0;
        scroll_en = 1'b0;
        model_reset();
        run(3);

        // Frame 1 (scroll 0); request scroll 10 at its vblank
        reset     = 1'b0;
        scroll_x  = 8'd10;
        scroll_en = 1'b1;
        run(9600);

        // Frame 2 (scroll 10); scroll_x wanders with latching disabled
        scroll_en = 1'b0;
        for (int k = 0; k < 12; k++) begin
            scroll_x = 8'($urandom);
            run(800);
        end

        // Frame 3 keeps scroll 10; request 200 -> 40
        scroll_x  = 8'd200;
        scroll_en = 1'b1;
        run(9600);

        // Frame 4 (scroll 40); scroll_x changes mid-frame, seen only next frame
        run(3200);
        scroll_x = 8'($urandom);
        run(6400);

        // Frame 5: random scroll_x / scroll_en every line
        for (int k = 0; k < 12; k++) begin
            scroll_x  = 8'($urandom);
            scroll_en = 1'($urandom_range(1, 0));
            run(800);
        end

        // Asynchronous reset mid-line at x=300
        for (int k = 0; k < H_TOT && mx[1] != 300; k++)
            run(1);
        check("reached reset point x", 32'(mx[1]), 32'd300);
        #2 reset = 1'b1;
        #1 model_reset();
        check_all();
        run(3);
        reset     = 1'b0;
        scroll_x  = 8'($urandom);
        scroll_en = 1'b1;
        run(12000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bg_scan_addr_gen.md
Name: bg_scan_addr_gen

Overview:
- Raster scan generator that drives background ROM readers: ROM pixel address, active-video flag and VGA sync for a 640x480 display.
- Maps each screen pixel to a 160x120 background image at 4x scale, with a per-frame horizontal scroll offset that wraps.
- Sits between the pixel-clock domain top level and the background ROM/palette readers.
- Those readers register RGB one cycle after the address, so this block emits hs/vs one cycle late to stay aligned with the colour.

Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch (H_TOTAL=800)
- V_VISIBLE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch (V_TOTAL=525)
- IMG_W, 160, image width in texels
- IMG_H, 120, image height in texels
- SCALE_SHIFT, 2, log2 of screen pixels per texel
- ADDR_W, 15, ROM address width

Ports:
- vga_clk  in  1  pixel clock; single clock domain
- reset  in  1  asynchronous, active-high
- scroll_x  in  8  requested horizontal scroll, in texels
- scroll_en  in  1  allow scroll_x to be latched at the next vblank start
- rom_address  out  ADDR_W  texel address for the current pixel
- blank  out  1  1 = visible pixel (colour enable for readers), 0 = blanking
- draw_x  out  10  current pixel column, 0..H_TOTAL-1
- draw_y  out  10  current pixel line, 0..V_TOTAL-1
- hs  out  1  horizontal sync, active-low, delayed one cycle
- vs  out  1  vertical sync, active-low, delayed one cycle
- frame_start  out  1  one-cycle pulse while pixel (0,0) is presented

Behaviour:
- All outputs are registered. No combinational path from any input to any output.
- Asynchronous reset values:
  - draw_x=0, draw_y=0, blank=0, rom_address=0, hs=1, vs=1, frame_start=0.
  - Internal horizontal counter = H_TOTAL-1, vertical counter = V_TOTAL-1, scroll_q=0, row_base=0, u=0, sub=0, vsub=0.
- First edge after reset release presents pixel (0,0): blank=1, rom_address=0, frame_start=1.
- Scan counters:
  - x increments every cycle and wraps H_TOTAL-1 -> 0.
  - On that wrap, y increments and wraps V_TOTAL-1 -> 0.
  - draw_x/draw_y report the pixel presented this cycle.
- blank = 1 iff draw_x < H_VISIBLE and draw_y < V_VISIBLE.
- Address generation is incremental; no multiplier.
  - sub counts 0..3 per pixel. When sub wraps, u increments; u wraps IMG_W-1 -> 0.
  - At x=0, u loads scroll_q and sub=0.
  - vsub counts lines 0..3. When vsub wraps, row_base += IMG_W.
  - At y=0, row_base=0 and vsub=0.
  - rom_address = row_base + u while blank=1; 0 while blank=0.
  - Maximum address is 119*160+159 = 19199.
- Scroll latching:
  - scroll_q updates only when the next pixel is (0, V_VISIBLE), the first vblank line, and only if scroll_en=1.
  - Latched value = scroll_x if scroll_x < IMG_W, else scroll_x - IMG_W. Since scroll_x ≤ 255, one subtraction suffices.
  - scroll_x changes at any other time have no effect on the current frame.
- Sync generation:
  - Raw hs_n = 0 when H_VISIBLE+H_FP ≤ x < H_VISIBLE+H_FP+H_SYNC (656..751).
  - Raw vs_n = 0 when V_VISIBLE+V_FP ≤ y < V_VISIBLE+V_FP+V_SYNC (490..491).
  - hs and vs are raw hs_n/vs_n delayed one more register, matching the readers' RGB latency.
- frame_start = 1 exactly when draw_x=0 and draw_y=0.
- Frame period: 420000 cycles.
- Reset asserted mid-frame: outputs take reset values immediately, with no clock edge required. The scan restarts at (0,0) after release.

Test Plan:
- Reset release -> first edge: draw_x=0, draw_y=0, blank=1, rom_address=0, frame_start=1, hs=1, vs=1.
- Line 0:
  - draw_x=3 -> addr 0; draw_x=4 -> addr 1; draw_x=639 -> addr 159.
  - draw_x=640 -> blank=0, addr 0.
  - hs falls on the edge after draw_x=656 and rises on the edge after draw_x=752.
- Rows:
  - (0,4) -> addr 160; (639,479) -> addr 19199.
  - (0,480) -> blank=0.
  - vs low during the cycles after draw_y=490..491.
  - frame_start pulses every 420000 cycles.
- Scroll: scroll_x=10, scroll_en=1 held across vblank start.
  - Next frame (0,0) -> addr 10.
  - (596,0) -> addr 159; (600,0) -> addr 0 (wrap).
  - (600,4) -> addr 160.
  - With scroll_en=0 the following frame keeps offset 10.
- scroll_x=200, scroll_en=1 -> next frame (0,0) addr 40. scroll_x changed mid-frame -> no address change until the next frame.
- Assert reset at (300,200) for 3 cycles -> outputs at reset values without a clock edge. After release, first edge shows (0,0), addr 0, scroll 0.
